// File: rtl/mem_data_ctrl_pkg.sv
// rtl/mem_data_ctrl_pkg.sv - shared states and constants for the MEM-stage data port responder
package mem_data_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam int          BYTE_W       = 8;

endpackage

// File: rtl/mem_data_ctrl_if.sv
// rtl/mem_data_ctrl_if.sv - MEM-stage request/response bundle between pipeline and data controller
interface mem_data_ctrl_if
  import mem_data_ctrl_pkg::*;
  ();

  logic                  mem_ce_i;
  logic                  mem_we_i;
  logic [31:0]           mem_addr_i;
  logic [3:0]            mem_sel_i;
  logic [4*BYTE_W-1:0]   mem_data_i;
  logic [4*BYTE_W-1:0]   mem_data_o;
  logic                  busy_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, busy_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, busy_o
  );

endinterface

// File: rtl/mem_data_ctrl.sv
// rtl/mem_data_ctrl.sv - serialises word load/store requests onto a byte-wide synchronous RAM
module mem_data_ctrl
  import mem_data_ctrl_pkg::*;
#(
  parameter int RAM_AW = 32,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  mem_data_ctrl_if.slave    mem,
  output logic [RAM_AW-1:0] ram_a_o,
  output logic [BYTE_W-1:0] ram_dout_o,
  output logic              ram_wr_o,
  input  logic [BYTE_W-1:0] ram_din_i
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         base_q, base_d;
  logic [2:0]          sel_hi_q, sel_hi_d;
  logic [23:0]         wdata_hi_q, wdata_hi_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [RAM_AW-1:0]   ram_a_q, ram_a_d;
  logic [BYTE_W-1:0]   ram_dout_q, ram_dout_d;
  logic                ram_wr_q, ram_wr_d;

  logic [31:0]         req_base;
  logic [31:0]         addr_next;

  assign req_base  = mem.mem_addr_i & ~32'h0000_0003;
  assign addr_next = base_q + 32'(cnt_q) + 32'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    sel_hi_d   = sel_hi_q;
    wdata_hi_d = wdata_hi_q;
    rdata_d    = rdata_q;
    ram_a_d    = ram_a_q;
    ram_dout_d = ram_dout_q;
    ram_wr_d   = ram_wr_q;

    case (state_q)
      ST_IDLE: begin
        ram_wr_d = 1'b0;
        if (mem.mem_ce_i == CHIP_ENABLE) begin
          // Lane 0 goes out straight from the request, so only lanes 1..3 are kept.
          base_d     = req_base;
          sel_hi_d   = mem.mem_sel_i[3:1];
          wdata_hi_d = mem.mem_data_i[31:8];
          cnt_d      = '0;
          ram_a_d    = RAM_AW'(req_base);
          if (mem.mem_we_i == WRITE_ENABLE) begin
            state_d    = ST_WR;
            ram_dout_d = mem.mem_data_i[7:0];
            ram_wr_d   = mem.mem_sel_i[0];
          end else begin
            state_d = ST_RD;
          end
        end
      end

      ST_RD: begin
        // RAM data lags the address by one cycle, so cnt=k captures byte k-1.
        case (cnt_q)
          CNT_W'(1): rdata_d[7:0]   = ram_din_i;
          CNT_W'(2): rdata_d[15:8]  = ram_din_i;
          CNT_W'(3): rdata_d[23:16] = ram_din_i;
          CNT_W'(4): rdata_d[31:24] = ram_din_i;
          default: ;
        endcase
        if (cnt_q < CNT_W'(4)) begin
          ram_a_d = RAM_AW'(addr_next);
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_WR: begin
        if (cnt_q < CNT_W'(3)) begin
          ram_a_d = RAM_AW'(addr_next);
          cnt_d   = cnt_q + CNT_W'(1);
          case (cnt_q)
            CNT_W'(0): begin
              ram_dout_d = wdata_hi_q[7:0];
              ram_wr_d   = sel_hi_q[0];
            end
            CNT_W'(1): begin
              ram_dout_d = wdata_hi_q[15:8];
              ram_wr_d   = sel_hi_q[1];
            end
            default: begin
              ram_dout_d = wdata_hi_q[23:16];
              ram_wr_d   = sel_hi_q[2];
            end
          endcase
        end else begin
          ram_wr_d = 1'b0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      base_q     <= ZERO_WORD;
      sel_hi_q   <= '0;
      wdata_hi_q <= '0;
      rdata_q    <= ZERO_WORD;
      ram_a_q    <= '0;
      ram_dout_q <= '0;
      ram_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      sel_hi_q   <= sel_hi_d;
      wdata_hi_q <= wdata_hi_d;
      rdata_q    <= rdata_d;
      ram_a_q    <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
    end
  end

  assign mem.busy_o     = (state_q == ST_IDLE) ? mem.mem_ce_i : (state_q != ST_DONE);
  assign mem.mem_data_o = rdata_q;
  assign ram_a_o        = ram_a_q;
  assign ram_dout_o     = ram_dout_q;
  assign ram_wr_o       = ram_wr_q;

endmodule

// File: tb/tb_mem_data_ctrl.sv
// tb/tb_mem_data_ctrl.sv - directed bench for mem_data_ctrl against a byte-wide synchronous RAM model
module tb_mem_data_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [7:0]  bd_data;
  logic [7:0]  ram [0:1023];
  int          n_chk;
  int          n_pass;

  mem_data_ctrl_if bus ();

  mem_data_ctrl #(.RAM_AW(32), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (bus),
    .ram_a_o    (ram_a),
    .ram_dout_o (ram_dout),
    .ram_wr_o   (ram_wr),
    .ram_din_i  (ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backdoor port lets the bench preload bytes without a second driver on the array.
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    ram_din <= ram[ram_a[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [7:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    tick();
    bd_we   = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bus.mem_ce_i   = 1'b1;
    bus.mem_we_i   = we;
    bus.mem_addr_i = a;
    bus.mem_sel_i  = s;
    bus.mem_data_i = d;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] base;
    base = a & ~32'h3;
    issue(1'b0, a, 4'hF, 32'h0);
    #1 check({tag, "_busy_t0"}, {31'b0, bus.busy_o}, 32'd1);
    tick();
    bus.mem_ce_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1 check($sformatf("%s_busy_t%0d", tag, k), {31'b0, bus.busy_o}, 32'd1);
      if (k <= 4) check($sformatf("%s_addr_t%0d", tag, k), ram_a, base + 32'(k - 1));
      tick();
    end
    #1 check({tag, "_busy_t6"}, {31'b0, bus.busy_o}, 32'd0);
    check({tag, "_data"}, bus.mem_data_o, exp);
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] base;
    base = a & ~32'h3;
    issue(1'b1, a, s, d);
    #1 check({tag, "_busy_t0"}, {31'b0, bus.busy_o}, 32'd1);
    tick();
    bus.mem_ce_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1 check($sformatf("%s_busy_t%0d", tag, k), {31'b0, bus.busy_o}, 32'd1);
      check($sformatf("%s_addr_t%0d", tag, k), ram_a, base + 32'(k - 1));
      check($sformatf("%s_wr_t%0d", tag, k), {31'b0, ram_wr}, {31'b0, s[k-1]});
      if (s[k-1]) check($sformatf("%s_byte_t%0d", tag, k), {24'b0, ram_dout}, {24'b0, d[8*(k-1) +: 8]});
      tick();
    end
    #1 check({tag, "_busy_t5"}, {31'b0, bus.busy_o}, 32'd0);
    check({tag, "_wr_t5"}, {31'b0, ram_wr}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    bd_we = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    bus.mem_ce_i = 1'b0;
    bus.mem_we_i = 1'b0;
    bus.mem_addr_i = '0;
    bus.mem_sel_i = '0;
    bus.mem_data_i = '0;
    repeat (3) tick();
    #1;
    check("rst_busy", {31'b0, bus.busy_o}, 32'd0);
    check("rst_data", bus.mem_data_o, 32'h0);
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_ram_dout", {24'b0, ram_dout}, 32'h0);
    check("rst_ram_wr", {31'b0, ram_wr}, 32'h0);
    rst = 1'b0;

    bd_write(10'h100, 8'h11);
    bd_write(10'h101, 8'h22);
    bd_write(10'h102, 8'h33);
    bd_write(10'h103, 8'h44);
    for (int i = 0; i < 4; i++) begin
      bd_write(10'h200 + 10'(i), 8'h00);
      bd_write(10'h300 + 10'(i), 8'h00);
    end

    tick();
    do_load("ld_word", 32'h102, 32'h4433_2211);

    tick();
    do_store("st_sb", 32'h201, 4'b0010, 32'h5A5A_5A5A);
    check("st_keeps_rdata", bus.mem_data_o, 32'h4433_2211);
    tick();
    do_load("ld_sb", 32'h200, 32'h0000_5A00);

    tick();
    do_store("st_sel0", 32'h100, 4'b0000, 32'hFFFF_FFFF);
    tick();
    do_load("ld_sel0", 32'h100, 32'h4433_2211);

    tick();
    do_store("st_sw", 32'h200, 4'b1111, 32'hDEAD_BEEF);
    tick();
    do_load("ld_b2b", 32'h200, 32'hDEAD_BEEF);

    tick();
    issue(1'b0, 32'h102, 4'hF, 32'h0);
    for (int k = 0; k <= 5; k++) begin
      #1 check($sformatf("held_busy_t%0d", k), {31'b0, bus.busy_o}, 32'd1);
      tick();
    end
    #1 check("held_done_busy", {31'b0, bus.busy_o}, 32'd0);
    check("held_data1", bus.mem_data_o, 32'h4433_2211);
    tick();
    #1 check("held_reissue_busy", {31'b0, bus.busy_o}, 32'd1);
    tick();
    bus.mem_ce_i = 1'b0;
    repeat (5) tick();
    #1 check("held_done2_busy", {31'b0, bus.busy_o}, 32'd0);
    check("held_data2", bus.mem_data_o, 32'h4433_2211);

    tick();
    issue(1'b1, 32'h300, 4'hF, 32'hDEAD_BEEF);
    tick();
    bus.mem_ce_i = 1'b0;
    tick();
    #1 check("mid_wr_before_rst", {31'b0, ram_wr}, 32'd1);
    rst = 1'b1;
    tick();
    #1;
    check("mid_rst_busy", {31'b0, bus.busy_o}, 32'd0);
    check("mid_rst_wr", {31'b0, ram_wr}, 32'd0);
    check("mid_rst_data", bus.mem_data_o, 32'h0);
    check("mid_rst_ram_a", ram_a, 32'h0);
    rst = 1'b0;
    tick();
    do_load("ld_partial", 32'h300, 32'h0000_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_data_ctrl.md
Name: mem_data_ctrl

Overview:
- Memory-side responder for the MEM-stage data port.
- Accepts word-level load/store requests (ce/we/addr/sel/wdata) and serves them over a byte-wide synchronous RAM port.
- Returns the assembled aligned word plus a busy flag; the MEM stage turns busy into a pipeline stall.
- Sits between the MEM stage and the data RAM; MEM performs lane extraction and sign extension.

Parameters:
RAM_AW, 32, width of the byte address driven to RAM
CNT_W, 3, width of the byte-sequence counter (must hold 0..4)

Ports:
clk  in  1  system clock, all state updated on rising edge
rst  in  1  reset
mem_ce_i  in  1  request valid (ChipEnable)
mem_we_i  in  1  1 = store, 0 = load
mem_addr_i  in  32  byte address; bits [1:0] ignored, base = {addr[31:2],2'b00}
mem_sel_i  in  4  byte-lane enables; bit i selects wdata[8i+7:8i]
mem_data_i  in  32  store data, already lane-replicated by MEM
mem_data_o  out  32  aligned word read from RAM (lane0 = base+0)
busy_o  out  1  request in progress; drives MEM fetching_data
ram_a_o  out  RAM_AW  RAM byte address (registered)
ram_dout_o  out  8  RAM write byte (registered)
ram_wr_o  out  1  RAM write strobe (registered)
ram_din_i  in  8  RAM read byte, valid one cycle after the address is presented

Behaviour:
- Reset rst, synchronous, active-high. It forces state IDLE, cnt=0, and all latched request fields to 0. Outputs during/after reset: mem_data_o=0, ram_a_o=0, ram_dout_o=0, ram_wr_o=0.
- States: IDLE, RD, WR, DONE.
- busy_o (combinational):
  - IDLE: busy_o = mem_ce_i.
  - RD, WR: busy_o = 1.
  - DONE: busy_o = 0.
- IDLE with mem_ce_i=1:
  - Latch base, we, sel, wdata; cnt<=0; ram_a<=base.
  - we=0: go to RD, ram_wr<=0.
  - we=1: go to WR, ram_dout<=wdata[7:0], ram_wr<=sel[0].
- IDLE with mem_ce_i=0: hold; ram_wr<=0.
- RD (cnt 0..4):
  - When cnt>=1, capture ram_din_i into mem_data_o byte lane cnt-1.
  - cnt<4: ram_a<=base+cnt+1, cnt<=cnt+1.
  - cnt=4: go to DONE.
  - All four bytes are always read regardless of sel.
- WR (cnt 0..3):
  - cnt<3: ram_a<=base+cnt+1, ram_dout<=wdata byte cnt+1, ram_wr<=sel[cnt+1], cnt<=cnt+1.
  - cnt=3: ram_wr<=0, go to DONE.
  - Disabled lanes take a cycle with ram_wr=0, so latency is fixed.
- DONE: busy_o=0, mem_data_o stable; unconditionally return to IDLE. The pipeline advances on this edge.
- Latency from the request cycle T (busy rises combinationally in T):
  - Load: busy high T..T+5, data valid T+6.
  - Store: busy high T..T+4, DONE at T+5.
- mem_data_o holds its last load value until the next load overwrites lanes. Stores do not modify it.
- Request inputs are sampled only in IDLE; changes during RD/WR are ignored.
- If the pipeline is held by another stall through DONE, the same request is re-issued from IDLE. This is acceptable: loads and stores are idempotent.
- Address arithmetic is modulo 2^RAM_AW; base+3 never crosses a word boundary.
- sel=0000 with we=1 performs 4 cycles with no write strobe, then DONE.
- Reset mid-RD/WR: next edge is IDLE with ram_wr=0. A partially written word is not rolled back.

Decomposition:
- Shared defines header:
  - State encodings (IDLE/RD/WR/DONE).
  - ChipEnable/WriteEnable/ZeroWord constants already in use.
  - Byte-lane width constant.
- No sub-module. Lane insert/extract is a small case statement inside the block.

Test Plan:
- Reset mid-store: assert rst at WR cnt=1 -> next cycle state IDLE, ram_wr_o=0, busy_o=0 with ce low, mem_data_o=0.
- Load: preload RAM[0x100..0x103]=0x11,0x22,0x33,0x44; ce=1 we=0 addr=0x102 -> busy 6 cycles, ram_a sequence 0x100..0x103, mem_data_o=0x44332211 with busy=0 at T+6.
- Store SW: addr=0x200 sel=1111 data=0xDEADBEEF -> ram_wr high 4 cycles at 0x200..0x203 with bytes EF,BE,AD,DE; busy low at T+5; readback 0xDEADBEEF.
- Store SB: addr=0x201 sel=0010 data=0x5A5A5A5A over RAM word 0x00000000 -> exactly one ram_wr pulse at 0x201; subsequent load returns 0x00005A00.
- Back-to-back: store then load issued in the cycle after DONE -> second transaction starts from IDLE with no lost cycle beyond DONE; load returns the newly stored value.
- Held request: keep ce=1 we=0 through DONE -> busy re-asserts the next cycle and the load repeats with the identical result.
